// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S sample feeder.
package i2s_pkg;

  localparam int unsigned SAMPLE_W = 24;
  typedef logic signed [SAMPLE_W-1:0] sample_t;

  localparam int unsigned UNDERRUN_CNT_W = 16;
  localparam logic [UNDERRUN_CNT_W-1:0] UNDERRUN_CNT_MAX = '1;

  localparam int unsigned DEFAULT_FIFO_DEPTH = 8;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with combinational head; DEPTH must be a power of two.
module sample_fifo #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]     level_q, level_d;
  logic              do_push, do_pop;

  assign full_o  = (level_q == (PtrW + 1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    level_d = level_q;
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/i2s_sample_feeder.sv
// Buffers mixer samples and presents one per LRCLK frame to the I2S serializer.
// Define I2S_FEEDER_ATTEN_EN to add the per-frame arithmetic-shift attenuator input.
module i2s_sample_feeder
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_W      = SAMPLE_W,
  parameter int unsigned FIFO_DEPTH  = DEFAULT_FIFO_DEPTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          LRCLK,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [DATA_W-1:0]             sample_out,
  output logic                          frame_tick,
  output logic                          underrun,
  output logic [UNDERRUN_CNT_W-1:0]     underrun_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef I2S_FEEDER_ATTEN_EN
  ,
  input  logic [3:0]                    atten
`endif
);

  logic [SYNC_STAGES-1:0]    sync_q;
  logic                      prev_q;
  logic                      rise;
  logic                      push, pop;
  logic                      fifo_full, fifo_empty;
  logic [DATA_W-1:0]         head, next_sample;
  logic [DATA_W-1:0]         sample_q;
  logic                      frame_tick_q, underrun_q;
  logic [UNDERRUN_CNT_W-1:0] underrun_cnt_q;

  // Only rising LRCLK edges start a frame; falling edges are ignored.
  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  assign in_ready = ~fifo_full;
  assign push     = in_valid & in_ready;
  assign pop      = rise & ~fifo_empty;

`ifdef I2S_FEEDER_ATTEN_EN
  assign next_sample = $unsigned($signed(head) >>> atten);
`else
  assign next_sample = head;
`endif

  sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (Clk),
    .rst_ni  (Reset_n),
    .push_i  (push),
    .wdata_i (in_data),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], LRCLK};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // A pushed word arriving in an empty-FIFO frame cycle waits for the next frame.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sample_q       <= '0;
      frame_tick_q   <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      frame_tick_q <= rise;
      underrun_q   <= rise & fifo_empty;
      if (pop) sample_q <= next_sample;
      if (rise && fifo_empty && (underrun_cnt_q != UNDERRUN_CNT_MAX)) begin
        underrun_cnt_q <= underrun_cnt_q + 1'b1;
      end
    end
  end

  assign sample_out     = sample_q;
  assign frame_tick     = frame_tick_q;
  assign underrun       = underrun_q;
  assign underrun_count = underrun_cnt_q;

endmodule

// File: tb/tb_i2s_sample_feeder.sv
// Directed self-checking bench for i2s_sample_feeder.
module tb_i2s_sample_feeder;

  localparam int unsigned DW    = 24;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned SS    = 2;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          LRCLK;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] sample_out;
  logic          frame_tick;
  logic          underrun;
  logic [15:0]   underrun_count;
  logic [3:0]    fifo_level;
`ifdef I2S_FEEDER_ATTEN_EN
  logic [3:0]    atten;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  int            tick_n, ur_n, lat;
  logic [DW-1:0] smp;
  logic [3:0]    lvl_tick;
  logic          rdy_tick;

  always #10 Clk = ~Clk;

  i2s_sample_feeder #(
    .DATA_W      (DW),
    .FIFO_DEPTH  (DEPTH),
    .SYNC_STAGES (SS)
  ) dut (
    .Clk            (Clk),
    .Reset_n        (Reset_n),
    .LRCLK          (LRCLK),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .sample_out     (sample_out),
    .frame_tick     (frame_tick),
    .underrun       (underrun),
    .underrun_count (underrun_count),
    .fifo_level     (fifo_level)
`ifdef I2S_FEEDER_ATTEN_EN
    ,
    .atten          (atten)
`endif
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    in_data  = d;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // One LRCLK period: high for 'half' cycles then low for 'half' cycles.
  task automatic frame(input int half);
    tick_n = 0;
    ur_n   = 0;
    lat    = 0;
    smp    = 'x;
    LRCLK  = 1'b1;
    for (int i = 0; i < half; i++) begin
      step();
      if (frame_tick) begin
        tick_n++;
        lat      = i + 1;
        smp      = sample_out;
        lvl_tick = fifo_level;
        rdy_tick = in_ready;
      end
      if (underrun) ur_n++;
    end
    LRCLK = 1'b0;
    for (int i = 0; i < half; i++) begin
      step();
      if (frame_tick) tick_n++;
      if (underrun) ur_n++;
    end
  endtask

  task automatic chk_frame(input string tag, input logic [DW-1:0] exp_smp, input int exp_ur);
    chk({tag, ".ticks"}, 32'(tick_n), 1);
    chk({tag, ".lat"}, 32'(lat), SS + 1);
    chk({tag, ".sample"}, 32'(smp), 32'(exp_smp));
    chk({tag, ".underrun"}, 32'(ur_n), 32'(exp_ur));
  endtask

  task automatic reset_dut();
    Reset_n  = 1'b0;
    LRCLK    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) step();
    Reset_n = 1'b1;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed hang expected finish");
    $fatal(1, "timeout");
  end

  initial begin
`ifdef I2S_FEEDER_ATTEN_EN
    atten = 4'd0;
`endif
    reset_dut();
    chk("reset.sample", 32'(sample_out), 0);
    chk("reset.tick", 32'(frame_tick), 0);
    chk("reset.underrun", 32'(underrun), 0);
    chk("reset.count", 32'(underrun_count), 0);
    chk("reset.level", 32'(fifo_level), 0);
    chk("reset.ready", 32'(in_ready), 1);

    // Three samples over three 48 kHz frames.
    push(24'h000100);
    push(24'h7FFFFF);
    push(24'h800000);
    chk("t1.level", 32'(fifo_level), 3);
    frame(520);
    chk_frame("t1.f0", 24'h000100, 0);
    frame(520);
    chk_frame("t1.f1", 24'h7FFFFF, 0);
    frame(520);
    chk_frame("t1.f2", 24'h800000, 0);
    chk("t1.level_end", 32'(fifo_level), 0);
    chk("t1.count", 32'(underrun_count), 0);

    // Reset clears sample_out; then two empty frames.
    reset_dut();
    chk("t2.sample_reset", 32'(sample_out), 0);
    frame(10);
    chk_frame("t2.f0", 24'h000000, 1);
    frame(10);
    chk_frame("t2.f1", 24'h000000, 1);
    chk("t2.count", 32'(underrun_count), 2);

    // Fill with in_valid held high; the 9th word must be refused.
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_data = 24'(32'h100 + k);
      step();
    end
    chk("t3.level_full", 32'(fifo_level), 8);
    chk("t3.ready_full", 32'(in_ready), 0);
    in_data = 24'h1FF;
    step();
    chk("t3.level_9th", 32'(fifo_level), 8);
    in_valid = 1'b0;
    frame(6);
    chk_frame("t3.pop0", 24'h000100, 0);
    chk("t3.level_pop", 32'(lvl_tick), 7);
    chk("t3.ready_pop", 32'(rdy_tick), 1);
    for (int k = 1; k < 8; k++) begin
      frame(6);
      chk_frame("t3.drain", 24'(32'h100 + k), 0);
    end
    chk("t3.level_end", 32'(fifo_level), 0);
    frame(6);
    chk_frame("t3.empty", 24'h000107, 1);
    chk("t3.count", 32'(underrun_count), 3);

    // Push in the exact frame-event cycle with the FIFO empty.
    LRCLK = 1'b1;
    step();
    step();
    in_data  = 24'h0ABCDE;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t4.tick", 32'(frame_tick), 1);
    chk("t4.underrun", 32'(underrun), 1);
    chk("t4.level", 32'(fifo_level), 1);
    chk("t4.sample_held", 32'(sample_out), 32'h000107);
    repeat (5) step();
    LRCLK = 1'b0;
    repeat (6) step();
    chk("t4.count", 32'(underrun_count), 4);
    frame(6);
    chk_frame("t4.next", 24'h0ABCDE, 0);
    chk("t4.level_end", 32'(fifo_level), 0);

    // Push and pop together with the FIFO non-empty: level unchanged.
    push(24'h111111);
    LRCLK = 1'b1;
    step();
    step();
    in_data  = 24'h222222;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t4b.tick", 32'(frame_tick), 1);
    chk("t4b.underrun", 32'(underrun), 0);
    chk("t4b.sample", 32'(sample_out), 32'h111111);
    chk("t4b.level", 32'(fifo_level), 1);
    repeat (5) step();
    LRCLK = 1'b0;
    repeat (6) step();
    frame(6);
    chk_frame("t4b.next", 24'h222222, 0);

    // Saturation of the underrun counter.
    force dut.underrun_cnt_q = 16'hFFFD;
    step();
    release dut.underrun_cnt_q;
    step();
    chk("t5.preload", 32'(underrun_count), 32'hFFFD);
    frame(6);
    chk_frame("t5.u0", 24'h222222, 1);
    chk("t5.count0", 32'(underrun_count), 32'hFFFE);
    frame(6);
    chk_frame("t5.u1", 24'h222222, 1);
    chk("t5.count1", 32'(underrun_count), 32'hFFFF);
    frame(6);
    chk_frame("t5.u2", 24'h222222, 1);
    chk("t5.count_sat", 32'(underrun_count), 32'hFFFF);

    // Reset mid-frame, released with LRCLK already high.
    push(24'h333333);
    push(24'h444444);
    chk("t6.level_pre", 32'(fifo_level), 2);
    LRCLK = 1'b1;
    step();
    Reset_n = 1'b0;
    #1;
    chk("t6.level_rst", 32'(fifo_level), 0);
    chk("t6.count_rst", 32'(underrun_count), 0);
    chk("t6.sample_rst", 32'(sample_out), 0);
    step();
    step();
    Reset_n = 1'b1;
    tick_n  = 0;
    ur_n    = 0;
    lat     = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (frame_tick) begin
        tick_n++;
        lat = i + 1;
      end
      if (underrun) ur_n++;
    end
    chk("t6.ticks", 32'(tick_n), 1);
    chk("t6.lat", 32'(lat), SS + 1);
    chk("t6.underrun", 32'(ur_n), 1);
    chk("t6.count", 32'(underrun_count), 1);
    chk("t6.sample", 32'(sample_out), 0);
    LRCLK = 1'b0;
    repeat (6) step();

`ifdef I2S_FEEDER_ATTEN_EN
    // Attenuation by arithmetic shift on newly popped samples only.
    atten = 4'd4;
    push(24'h800000);
    frame(6);
    chk_frame("t7.att4", 24'hF80000, 0);
    atten = 4'd0;
    push(24'h010000);
    frame(6);
    chk_frame("t7.att0", 24'h010000, 0);
    atten = 4'd4;
    frame(6);
    chk_frame("t7.held", 24'h010000, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
